// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with single-request line refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct #(
  parameter int LINES = 8,
  parameter int IDX_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   IR_addr,
  output logic [31:0]   IR,
  output logic          ic_stall,
  input  logic          flush,
  output logic          mem_read,
  output logic [27:0]   mem_addr,
  input  logic [127:0]  mem_rdata,
`ifdef ICACHE_STATS_EN
  input  logic          mem_ready,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`else
  input  logic          mem_ready
`endif
);

  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state, state_nxt;
  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_store  [LINES];
  logic [127:0]       data_store [LINES];
  logic               flush_pend;

  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         offset;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               start_fill;
  logic               fill_done;
  logic [127:0]       line_rd;
  logic [31:0]        hit_word;
  logic               unused_addr_bits;

  assign idx    = IR_addr[IDX_W+3:4];
  assign tag    = IR_addr[31:IDX_W+4];
  assign offset = IR_addr[3:2];
  assign unused_addr_bits = ^IR_addr[1:0];

  // The refill targets the latched line, not whatever the core presents now.
  assign fill_idx = mem_addr[IDX_W-1:0];
  assign fill_tag = mem_addr[27:IDX_W];

  assign hit        = valid[idx] && (tag_store[idx] == tag);
  assign start_fill = (state == IDLE) && !hit;
  assign fill_done  = (state == FILL) && mem_read && mem_ready;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    line_rd  = data_store[idx];
    hit_word = line_rd[31:0];
    unique case (offset)
      2'd0: hit_word = line_rd[31:0];
      2'd1: hit_word = line_rd[63:32];
      2'd2: hit_word = line_rd[95:64];
      2'd3: hit_word = line_rd[127:96];
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_fill) state_nxt = FILL;
      FILL: if (fill_done)  state_nxt = IDLE;
    endcase
  end

  // FSM: outputs to the core
  always_comb begin
    IR       = '0;
    ic_stall = 1'b1;
    if ((state == IDLE) && hit) begin
      IR       = hit_word;
      ic_stall = 1'b0;
    end
  end

  // Request handshake, valid bits and deferred flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      valid      <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (start_fill) begin
        mem_read <= 1'b1;
        mem_addr <= IR_addr[31:4];
      end else if (fill_done) begin
        mem_read <= 1'b0;
      end

      if ((state == IDLE) && flush) valid <= '0;

      if (state == FILL) begin
        if (flush) flush_pend <= 1'b1;
        if (fill_done) begin
          flush_pend <= 1'b0;
          // A flush seen at any point during the fill also discards the new line.
          if (flush_pend || flush) valid <= '0;
          else                     valid[fill_idx] <= 1'b1;
        end
      end
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_store[fill_idx] <= mem_rdata;
      tag_store[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == IDLE) && hit) hit_cnt  <= hit_cnt + 32'd1;
      if (start_fill)             miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct (LINES=8, IDX_W=3).
// Counter checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_direct;

  logic          clk;
  logic          rst_n;
  logic [31:0]   IR_addr;
  logic [31:0]   IR;
  logic          ic_stall;
  logic          flush;
  logic          mem_read;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
`ifdef ICACHE_STATS_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  icache_direct #(.LINES(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .IR_addr   (IR_addr),
    .IR        (IR),
    .ic_stall  (ic_stall),
    .flush     (flush),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
`ifdef ICACHE_STATS_EN
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`else
    .mem_ready (mem_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp)
      else begin
        failures++;
        $error("FAIL %s: got %0h expected %0h", name, got, exp);
      end
  endtask

  // Memory image: each word holds its own byte address.
  function automatic logic [127:0] line_of(input logic [31:0] addr);
    logic [31:0] base;
    base = {addr[31:4], 4'b0000};
    return {base + 32'd12, base + 32'd8, base + 32'd4, base};
  endfunction

  // Miss on addr, mem_ready on the n-th FILL cycle, then expect a hit.
  task automatic do_miss(input logic [31:0] addr, input int n, input string nm);
    int stalls;
    stalls = 0;
    @(negedge clk);
    IR_addr = addr; mem_ready = 1'b0; #1;
    check({nm, " miss stall"}, ic_stall, 1'b1);
    check({nm, " miss IR"}, IR, 32'h0);
    if (ic_stall) stalls++;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == n) begin
        mem_ready = 1'b1;
        mem_rdata = line_of(addr);
      end
      #1;
      check({nm, " fill mem_read"}, mem_read, 1'b1);
      check({nm, " fill mem_addr"}, mem_addr, addr[31:4]);
      if (ic_stall) stalls++;
    end
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check({nm, " post stall"}, ic_stall, 1'b0);
    check({nm, " post IR"}, IR, addr & 32'hFFFF_FFFC);
    check({nm, " post mem_read"}, mem_read, 1'b0);
    check({nm, " stall cycles"}, stalls, n + 1);
  endtask

  task automatic expect_hit(input logic [31:0] addr, input string nm);
    @(negedge clk);
    IR_addr = addr; #1;
    check({nm, " stall"}, ic_stall, 1'b0);
    check({nm, " IR"}, IR, addr & 32'hFFFF_FFFC);
    check({nm, " mem_read"}, mem_read, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; IR_addr = 32'h0; flush = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    check("reset mem_read", mem_read, 1'b0);
    check("reset mem_addr", mem_addr, 28'h0);
    check("reset stall", ic_stall, 1'b1);
    check("reset IR", IR, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Cold miss with ready on first FILL cycle, then word sweep.
    do_miss(32'h0000_0000, 1, "cold");
    expect_hit(32'h0, "sweep0");
    expect_hit(32'h4, "sweep1");
    expect_hit(32'h8, "sweep2");
    expect_hit(32'hC, "sweep3");

    // Conflict on index 0, then back.
    do_miss(32'h0000_0080, 1, "conflict");
    do_miss(32'h0000_0000, 1, "return");

    // Slow memory: ready on 5th FILL cycle.
    do_miss(32'h0000_0124, 5, "slow");

    // Flush during FILL: line not kept, immediate re-miss.
    @(negedge clk);
    IR_addr = 32'h0000_0200; #1;
    check("fflush miss stall", ic_stall, 1'b1);
    @(negedge clk);
    flush = 1'b1; #1;
    check("fflush mem_read", mem_read, 1'b1);
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b1; mem_rdata = line_of(32'h200); #1;
    check("fflush done stall", ic_stall, 1'b1);
    do_miss(32'h0000_0200, 1, "refetch");
    do_miss(32'h0000_0124, 1, "flushed_other");

    // Flush in IDLE on a hit, then flush coincident with the miss.
    @(negedge clk);
    flush = 1'b1; #1;
    check("iflush hit stall", ic_stall, 1'b0);
    check("iflush hit IR", IR, 32'h0000_0124);
    @(negedge clk);
    #1;
    check("iflush next stall", ic_stall, 1'b1);
    check("iflush next mem_read", mem_read, 1'b0);
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b1; mem_rdata = line_of(32'h120); #1;
    check("coinc fill mem_read", mem_read, 1'b1);
    check("coinc fill mem_addr", mem_addr, 28'h000_0012);
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check("coinc post stall", ic_stall, 1'b0);
    check("coinc post IR", IR, 32'h0000_0124);

    // mem_ready while mem_read=0 is ignored.
    @(negedge clk);
    IR_addr = 32'h0000_0300; mem_ready = 1'b1; mem_rdata = line_of(32'h300); #1;
    check("ign miss stall", ic_stall, 1'b1);
    check("ign miss mem_read", mem_read, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check("ign fill mem_read", mem_read, 1'b1);
    check("ign fill stall", ic_stall, 1'b1);
    @(negedge clk);
    mem_ready = 1'b1; #1;
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check("ign post stall", ic_stall, 1'b0);
    check("ign post IR", IR, 32'h0000_0300);

    // Reset mid-FILL, stale ready afterwards.
    @(negedge clk);
    IR_addr = 32'h0000_0400; #1;
    check("rst miss stall", ic_stall, 1'b1);
    @(negedge clk);
    #1;
    check("rst fill mem_read", mem_read, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst async mem_read", mem_read, 1'b0);
    check("rst async mem_addr", mem_addr, 28'h0);
    check("rst async stall", ic_stall, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = line_of(32'h400); #1;
    check("stale idle mem_read", mem_read, 1'b0);
    check("stale idle stall", ic_stall, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check("stale refill mem_read", mem_read, 1'b1);
    check("stale refill stall", ic_stall, 1'b1);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = line_of(32'h400); #1;
    @(negedge clk);
    mem_ready = 1'b0; #1;
    check("post-rst hit IR", IR, 32'h0000_0400);
    do_miss(32'h0000_0124, 1, "post-rst cleared");

    // Fresh reset, one miss then four hits.
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("rst2 stall", ic_stall, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    do_miss(32'h0000_0000, 1, "stats miss");
    expect_hit(32'h4, "stats hit1");
    expect_hit(32'h8, "stats hit2");
    expect_hit(32'hC, "stats hit3");
    @(negedge clk);
    #1;
`ifdef ICACHE_STATS_EN
    check("hit_cnt", hit_cnt, 32'd4);
    check("miss_cnt", miss_cnt, 32'd1);
`endif
    check("final stall", ic_stall, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
